instr_reg_scheduler: RTL and testbench

//  - Shares one instruction register (32-entry, opcode/operand_a/operand_b write port, read by pointer) among NUM_REQ requesters.
//  - Round-robin arbitration with valid/ready handshake; drives load_en, write_pointer, opcode and operands into the register.
//  - Manages read_pointer as FIFO head: consumers pop computed instruction_words in write order. Sits between stimulus sources and instr_register.

---
 rtl/instr_reg_scheduler_pkg.sv | 36 +++
 rtl/instr_reg_scheduler_rr_arbiter.sv | 76 +++++++
 rtl/instr_reg_scheduler.sv | 157 +++++++++++++++
 tb/tb_instr_reg_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_reg_scheduler_pkg.sv
// Shared types for the instruction register scheduler.
// Provides the instruction register types (opcode_t, operand_t, address_t),
// the scheduler FSM state type, default sizing constants and a small opcode
// classification helper.
package instr_reg_scheduler_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } sched_state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DEPTH_DEF   = 32;
    localparam int ADDR_W_DEF  = 5;

    // True for opcodes that divide by operand_b.
    function automatic logic is_div_op(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/instr_reg_scheduler_rr_arbiter.sv
// Round-robin arbiter with a rotating priority register.
// Ports:
//   clk, reset   clock and synchronous active-high reset (priority -> req 0)
//   req          request vector, one bit per requester
//   enable       when low no grant is issued and priority holds
//   grant        one-hot grant (combinational)
//   grant_idx    index of the granted requester (0 when no grant)
//   grant_valid  a grant is issued this cycle; priority advances past it
module instr_reg_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] prio_r;
    logic [IDX_W:0]   cand_s;
    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Search requesters starting at the priority pointer, wrapping once.
    always_comb begin
        cand_s  = '0;
        idx_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, prio_r} + (IDX_W+1)'(k);
            if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
                cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && enable && req[cand_s[IDX_W-1:0]]) begin
                found_s = 1'b1;
                idx_s   = cand_s[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // One-hot grant decode.
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign grant_idx   = idx_s;
    assign grant_valid = found_s;

    // Priority moves to the requester after the one just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r <= '0;
        end else if (found_s) begin
            if (idx_s == IDX_W'(NUM_REQ-1)) begin
                prio_r <= '0;
            end else begin
                prio_r <= idx_s + IDX_W'(1);
            end
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/instr_reg_scheduler.sv
// Instruction register scheduler: arbitrates NUM_REQ requesters onto the
// single write port of the instruction register and tracks it as a FIFO.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot)
//   req_opcode/req_operand_*   per-requester instruction fields
//   load_en, write_pointer     register write strobe and tail address
//   opcode, operand_a/b        fields of the granted requester
//   read_pointer, rd_valid     head address and non-empty indication
//   rd_ready                   consumer pop
//   flush                      discard all entries (pointers/count -> 0)
//   count                      occupied entries, 0..DEPTH
//   grant_id                   index of last granted requester
//   err_divzero                one-cycle pulse after a rejected divide by 0
// Optional feature: define DIVZERO_GUARD_EN to handshake-and-drop DIV/MOD
// requests whose operand_b is zero; otherwise they are written normally.
module instr_reg_scheduler
    import instr_reg_scheduler_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int GID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  opcode_t            req_opcode    [NUM_REQ],
    input  operand_t           req_operand_a [NUM_REQ],
    input  operand_t           req_operand_b [NUM_REQ],
    output logic               load_en,
    output logic [ADDR_W-1:0]  write_pointer,
    output opcode_t            opcode,
    output operand_t           operand_a,
    output operand_t           operand_b,
    output logic [ADDR_W-1:0]  read_pointer,
    output logic               rd_valid,
    input  logic               rd_ready,
    input  logic               flush,
    output logic [ADDR_W:0]    count,
    output logic [GID_W-1:0]   grant_id,
    output logic               err_divzero
);

    sched_state_e      state_r, state_s;
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic [GID_W-1:0]  grant_id_r;
    logic              err_divzero_r;

    logic              arb_en_s;
    logic              accept_s;
    logic [GID_W-1:0]  grant_idx_s;
    logic              divzero_s;
    logic              push_s;
    logic              pop_s;

    // No grant while full (even with a simultaneous pop), flushing or in reset.
    assign arb_en_s = !reset && !flush && (state_r != FULL);

    instr_reg_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GID_W)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .enable      (arb_en_s),
        .grant       (req_ready),
        .grant_idx   (grant_idx_s),
        .grant_valid (accept_s)
    );

    assign opcode    = req_opcode[grant_idx_s];
    assign operand_a = req_operand_a[grant_idx_s];
    assign operand_b = req_operand_b[grant_idx_s];

`ifdef DIVZERO_GUARD_EN
    assign divzero_s = accept_s && is_div_op(opcode) && (operand_b == '0);
`else
    assign divzero_s = 1'b0;
`endif

    assign push_s        = accept_s && !divzero_s;
    assign load_en       = push_s;
    assign write_pointer = wr_ptr_r;
    assign rd_valid      = !reset && (count_r != '0);
    assign pop_s         = rd_valid && rd_ready;

    // Next pointer/count/state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (flush) begin
            wr_ptr_s = '0;
            rd_ptr_s = '0;
            count_s  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + ADDR_W'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + ADDR_W'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_s = count_r + (ADDR_W+1)'(1);
            end else if (!push_s && pop_s) begin
                count_s = count_r - (ADDR_W+1)'(1);
            end else begin
                count_s = count_r;
            end
        end
        if (count_s == '0) begin
            state_s = EMPTY;
        end else if (count_s == (ADDR_W+1)'(DEPTH)) begin
            state_s = FULL;
        end else begin
            state_s = ACTIVE;
        end
    end

    // State, pointer, grant history and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= EMPTY;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            grant_id_r    <= '0;
            err_divzero_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            count_r       <= count_s;
            err_divzero_r <= divzero_s;
            if (accept_s) begin
                grant_id_r <= grant_idx_s;
            end else begin
                grant_id_r <= grant_id_r;
            end
        end
    end

    assign read_pointer = rd_ptr_r;
    assign count        = count_r;
    assign grant_id     = grant_id_r;
    assign err_divzero  = err_divzero_r;

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Directed self-checking bench for instr_reg_scheduler.
module tb_instr_reg_scheduler;
    import instr_reg_scheduler_pkg::*;

    localparam int NUM_REQ = 4;

    logic               clk;
    logic               reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    opcode_t            req_opcode    [NUM_REQ];
    operand_t           req_operand_a [NUM_REQ];
    operand_t           req_operand_b [NUM_REQ];
    logic               load_en;
    logic [4:0]         write_pointer;
    opcode_t            opcode;
    operand_t           operand_a;
    operand_t           operand_b;
    logic [4:0]         read_pointer;
    logic               rd_valid;
    logic               rd_ready;
    logic               flush;
    logic [5:0]         count;
    logic [1:0]         grant_id;
    logic               err_divzero;

    int checks = 0;
    int errors = 0;

    instr_reg_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .load_en       (load_en),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .flush         (flush),
        .count         (count),
        .grant_id      (grant_id),
        .err_divzero   (err_divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        rd_ready  = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_opcode[i]    = ZERO;
            req_operand_a[i] = 32'sd0;
            req_operand_b[i] = 32'sd0;
        end

        // Reset state, requests ignored while reset is high
        next_cycle();
        next_cycle();
        req_valid = 4'b1111;
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'h0);
        check_val("rst_load_en", 32'(load_en), 32'h0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_wp", 32'(write_pointer), 32'd0);
        check_val("rst_rp", 32'(read_pointer), 32'd0);
        check_val("rst_gid", 32'(grant_id), 32'd0);
        check_val("rst_err", 32'(err_divzero), 32'd0);

        // Test 1: single ADD 5,3 from requester 0
        next_cycle();
        reset            = 1'b0;
        req_valid        = 4'b0001;
        req_opcode[0]    = ADD;
        req_operand_a[0] = 32'sd5;
        req_operand_b[0] = 32'sd3;
        @(negedge clk);
        check_val("t1_load_en", 32'(load_en), 32'h1);
        check_val("t1_ready", 32'(req_ready), 32'h1);
        check_val("t1_wp", 32'(write_pointer), 32'd0);
        check_val("t1_opcode", 32'(opcode), 32'(ADD));
        check_val("t1_opa", 32'(operand_a), 32'd5);
        check_val("t1_opb", 32'(operand_b), 32'd3);
        check_val("t1_rd_valid_pre", 32'(rd_valid), 32'h0);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t1_rd_valid", 32'(rd_valid), 32'h1);
        check_val("t1_count", 32'(count), 32'd1);
        check_val("t1_rp", 32'(read_pointer), 32'd0);
        check_val("t1_wp_next", 32'(write_pointer), 32'd1);

        // Reset mid-operation, then test 2: all requesters for 8 cycles
        reset = 1'b1;
        next_cycle();
        reset     = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        check_val("t2_count0", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
            end
            check_val("t2_wp", 32'(write_pointer), 32'(i));
            check_val("t2_ready", 32'(req_ready), 32'(1 << (i % 4)));
            check_val("t2_load_en", 32'(load_en), 32'h1);
            if (i > 0) begin
                check_val("t2_gid", 32'(grant_id), 32'((i - 1) % 4));
            end
            next_cycle();
        end
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t2_gid_last", 32'(grant_id), 32'd3);
        check_val("t2_count", 32'(count), 32'd8);
        check_val("t2_wp_end", 32'(write_pointer), 32'd8);

        // Test 4: drain to 5, then simultaneous push and pop
        next_cycle();
        rd_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        req_valid = 4'b0001;
        @(negedge clk);
        check_val("t4_count_pre", 32'(count), 32'd5);
        check_val("t4_load_en", 32'(load_en), 32'h1);
        check_val("t4_rd_valid", 32'(rd_valid), 32'h1);
        next_cycle();
        rd_ready  = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t4_count", 32'(count), 32'd5);
        check_val("t4_rp", 32'(read_pointer), 32'd4);
        check_val("t4_wp", 32'(write_pointer), 32'd9);

        // Test 5: fill to 10 from requester 1, then flush with requests pending
        next_cycle();
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
        end
        req_valid = 4'b1111;
        flush     = 1'b1;
        @(negedge clk);
        check_val("t5_count_pre", 32'(count), 32'd10);
        check_val("t5_ready", 32'(req_ready), 32'h0);
        check_val("t5_load_en", 32'(load_en), 32'h0);
        check_val("t5_gid_pre", 32'(grant_id), 32'd1);
        next_cycle();
        flush     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t5_count", 32'(count), 32'd0);
        check_val("t5_rd_valid", 32'(rd_valid), 32'h0);
        check_val("t5_rp", 32'(read_pointer), 32'd0);
        check_val("t5_wp", 32'(write_pointer), 32'd0);
        check_val("t5_gid", 32'(grant_id), 32'd1);

        // Test 3: fill all 32 entries, FULL blocks accept even with a pop
        next_cycle();
        req_valid = 4'b0001;
        for (int i = 0; i < 32; i++) begin
            next_cycle();
        end
        @(negedge clk);
        check_val("t3_count_full", 32'(count), 32'd32);
        check_val("t3_ready_full", 32'(req_ready), 32'h0);
        check_val("t3_load_full", 32'(load_en), 32'h0);
        check_val("t3_wp_wrap", 32'(write_pointer), 32'd0);
        next_cycle();
        rd_ready = 1'b1;
        @(negedge clk);
        check_val("t3_ready_pop", 32'(req_ready), 32'h0);
        check_val("t3_load_pop", 32'(load_en), 32'h0);
        next_cycle();
        rd_ready = 1'b0;
        @(negedge clk);
        check_val("t3_count_31", 32'(count), 32'd31);
        check_val("t3_rp", 32'(read_pointer), 32'd1);
        check_val("t3_load_resume", 32'(load_en), 32'h1);
        check_val("t3_wp_resume", 32'(write_pointer), 32'd0);
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
        check_val("t3_count_refill", 32'(count), 32'd32);
        check_val("t3_wp_after", 32'(write_pointer), 32'd1);

        // Test 6: DIV by zero from requester 2
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush            = 1'b0;
        req_valid        = 4'b0100;
        req_opcode[2]    = DIV;
        req_operand_a[2] = 32'sd7;
        req_operand_b[2] = 32'sd0;
        @(negedge clk);
        check_val("t6_ready", 32'(req_ready), 32'h4);
`ifdef DIVZERO_GUARD_EN
        check_val("t6_load_en", 32'(load_en), 32'h0);
`else
        check_val("t6_load_en", 32'(load_en), 32'h1);
`endif
        next_cycle();
        req_valid = 4'b0000;
        @(negedge clk);
`ifdef DIVZERO_GUARD_EN
        check_val("t6_err", 32'(err_divzero), 32'h1);
        check_val("t6_count", 32'(count), 32'd0);
`else
        check_val("t6_err", 32'(err_divzero), 32'h0);
        check_val("t6_count", 32'(count), 32'd1);
`endif
        check_val("t6_gid", 32'(grant_id), 32'd2);
        next_cycle();
        @(negedge clk);
        check_val("t6_err_clear", 32'(err_divzero), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
